// File: rtl/attn_row_sequencer.sv
// Row sequencer for the online-softmax attention pipeline: Q-load request, then K/V row stream per query.
// Optional stall counter on the K/V port is built only when ROW_STALL_CNT_EN is defined.
module attn_row_sequencer #(
  parameter int MAX_SEQ      = 64,
  parameter int MAX_Q        = 64,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(MAX_SEQ):0]   seq_len,
  input  logic [$clog2(MAX_Q):0]     num_q,
  output logic                       busy,
  output logic                       done,
  output logic                       q_req_vld,
  input  logic                       q_req_rdy,
  output logic [$clog2(MAX_Q)-1:0]   q_idx,
  output logic                       kv_vld,
  input  logic                       kv_rdy,
  output logic [$clog2(MAX_SEQ)-1:0] kv_idx,
  output logic                       kv_first,
  output logic                       kv_last,
  input  logic                       row_done,
  output logic [31:0]                stall_cnt
);

  localparam int SW = $clog2(MAX_SEQ);
  localparam int QW = $clog2(MAX_Q);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [SW:0]   SEQ_MAX = (SW + 1)'(MAX_SEQ);
  localparam logic [QW:0]   Q_MAX   = (QW + 1)'(MAX_Q);
  localparam logic [IW-1:0] IF_MAX  = IW'(MAX_INFLIGHT);

  typedef enum logic [1:0] {S_IDLE, S_LOAD_Q, S_STREAM, S_DRAIN} state_t;

  state_t        state_q, state_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          q_req_vld_q, q_req_vld_d;
  logic [QW-1:0] q_idx_q, q_idx_d;
  logic          kv_vld_q, kv_vld_d;
  logic [SW-1:0] kv_idx_q, kv_idx_d;
  logic          kv_first_q, kv_first_d;
  logic          kv_last_q, kv_last_d;
  logic [SW:0]   seq_len_q, seq_len_d;
  logic [QW:0]   num_q_q, num_q_d;
  logic [IW-1:0] inflight_q, inflight_d;

  logic          q_hs, kv_hs, rd_dec, can_req;
  logic [SW:0]   seq_clamp;
  logic [QW:0]   numq_clamp;

  assign q_hs       = q_req_vld_q && q_req_rdy;
  assign kv_hs      = kv_vld_q && kv_rdy;
  assign rd_dec     = row_done && (inflight_q != '0);
  assign seq_clamp  = (seq_len > SEQ_MAX) ? SEQ_MAX : seq_len;
  assign numq_clamp = (num_q > Q_MAX) ? Q_MAX : num_q;

  // Request eligibility looks at the post-update count so a row_done frees a slot on the very next cycle.
  always_comb begin
    inflight_d = inflight_q;
    if (q_hs && !rd_dec) begin
      inflight_d = inflight_q + IW'(1);
    end else if (!q_hs && rd_dec) begin
      inflight_d = inflight_q - IW'(1);
    end
    can_req = (inflight_d < IF_MAX);
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    q_req_vld_d = q_req_vld_q;
    q_idx_d     = q_idx_q;
    kv_vld_d    = kv_vld_q;
    kv_idx_d    = kv_idx_q;
    kv_first_d  = kv_first_q;
    kv_last_d   = kv_last_q;
    seq_len_d   = seq_len_q;
    num_q_d     = num_q_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          seq_len_d = seq_clamp;
          num_q_d   = numq_clamp;
          if (seq_clamp == '0 || numq_clamp == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = S_LOAD_Q;
            busy_d      = 1'b1;
            q_idx_d     = '0;
            kv_idx_d    = '0;
            q_req_vld_d = can_req;
          end
        end
      end

      S_LOAD_Q: begin
        if (q_hs) begin
          q_req_vld_d = 1'b0;
          state_d     = S_STREAM;
          kv_vld_d    = 1'b1;
          kv_idx_d    = '0;
          kv_first_d  = 1'b1;
          kv_last_d   = (seq_len_q == (SW + 1)'(1));
        end else begin
          // inflight cannot grow without our own handshake, so a raised request never drops.
          q_req_vld_d = can_req;
        end
      end

      S_STREAM: begin
        if (kv_hs) begin
          if (kv_last_q) begin
            kv_vld_d   = 1'b0;
            kv_idx_d   = '0;
            kv_first_d = 1'b0;
            kv_last_d  = 1'b0;
            if ((QW + 1)'(q_idx_q) + (QW + 1)'(1) == num_q_q) begin
              state_d = S_DRAIN;
            end else begin
              q_idx_d     = q_idx_q + QW'(1);
              state_d     = S_LOAD_Q;
              q_req_vld_d = can_req;
            end
          end else begin
            kv_idx_d   = kv_idx_q + SW'(1);
            kv_first_d = 1'b0;
            kv_last_d  = ((SW + 1)'(kv_idx_q) + (SW + 1)'(2) == seq_len_q);
          end
        end
      end

      S_DRAIN: begin
        if (inflight_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      q_req_vld_q <= 1'b0;
      q_idx_q     <= '0;
      kv_vld_q    <= 1'b0;
      kv_idx_q    <= '0;
      kv_first_q  <= 1'b0;
      kv_last_q   <= 1'b0;
      seq_len_q   <= '0;
      num_q_q     <= '0;
      inflight_q  <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      q_req_vld_q <= q_req_vld_d;
      q_idx_q     <= q_idx_d;
      kv_vld_q    <= kv_vld_d;
      kv_idx_q    <= kv_idx_d;
      kv_first_q  <= kv_first_d;
      kv_last_q   <= kv_last_d;
      seq_len_q   <= seq_len_d;
      num_q_q     <= num_q_d;
      inflight_q  <= inflight_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign q_req_vld = q_req_vld_q;
  assign q_idx     = q_idx_q;
  assign kv_vld    = kv_vld_q;
  assign kv_idx    = kv_idx_q;
  assign kv_first  = kv_first_q;
  assign kv_last   = kv_last_q;

`ifdef ROW_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Backpressure cycles on the K/V port, restarted by every accepted job start.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      stall_cnt_q <= '0;
    end else if (kv_vld_q && !kv_rdy && stall_cnt_q != '1) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_attn_row_sequencer.sv
// Scoreboard bench for attn_row_sequencer: directed jobs push expected Q requests / K/V beats,
// a negedge monitor pops and compares on every handshake and done pulse.
module tb_attn_row_sequencer;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [6:0]  seq_len, num_q;
  logic        busy, done, q_req_vld, q_req_rdy;
  logic [5:0]  q_idx, kv_idx;
  logic        kv_vld, kv_rdy, kv_first, kv_last;
  logic        row_done, rd_auto, rd_man, auto_en;
  logic [31:0] stall_cnt;

  assign row_done = rd_auto | rd_man;

  always #5 clk = ~clk;

  attn_row_sequencer #(.MAX_SEQ(64), .MAX_Q(64), .MAX_INFLIGHT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .seq_len(seq_len), .num_q(num_q),
    .busy(busy), .done(done), .q_req_vld(q_req_vld), .q_req_rdy(q_req_rdy),
    .q_idx(q_idx), .kv_vld(kv_vld), .kv_rdy(kv_rdy), .kv_idx(kv_idx),
    .kv_first(kv_first), .kv_last(kv_last), .row_done(row_done), .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic [5:0] q;
    logic [5:0] k;
    logic       f;
    logic       l;
  } beat_t;

  beat_t      exp_kv[$];
  logic [5:0] exp_q[$];
  int         exp_done  = 0;
  int         done_seen = 0;
  int         n_chk     = 0;
  int         n_fail    = 0;
  int         timers[8];
  logic       prev_stall = 1'b0;
  beat_t      prev_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_job(input int sl, input int nq);
    beat_t b;
    for (int q = 0; q < nq; q++) begin
      exp_q.push_back(6'(q));
      for (int k = 0; k < sl; k++) begin
        b.q = 6'(q);
        b.k = 6'(k);
        b.f = (k == 0);
        b.l = (k == sl - 1);
        exp_kv.push_back(b);
      end
    end
    exp_done++;
  endtask

  task automatic do_start(input int sl, input int nq);
    @(posedge clk); #1;
    seq_len = 7'(sl);
    num_q   = 7'(nq);
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_seen > base) break;
    end
    #1;
    chk("done_count", 32'(done_seen - base), 32'd1);
  endtask

  task automatic end_checks();
    chk("kv_queue_drained", 32'(exp_kv.size()), 32'd0);
    chk("q_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("done_outstanding", 32'(exp_done), 32'd0);
  endtask

  task automatic check_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q_req_vld", 32'(q_req_vld), 32'd0);
    chk("rst_kv_vld", 32'(kv_vld), 32'd0);
    chk("rst_kv_first", 32'(kv_first), 32'd0);
    chk("rst_kv_last", 32'(kv_last), 32'd0);
    chk("rst_q_idx", 32'(q_idx), 32'd0);
    chk("rst_kv_idx", 32'(kv_idx), 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
  endtask

  // Monitor: compares on handshakes, checks hold-during-stall, and models row_done 3 cycles after kv_last.
  always @(negedge clk) begin
    beat_t cur;
    beat_t e;
    logic [5:0] eq;
    cur = {q_idx, kv_idx, kv_first, kv_last};
    if (rst) begin
      prev_stall = 1'b0;
      rd_auto    = 1'b0;
      for (int i = 0; i < 8; i++) timers[i] = 0;
    end else begin
      rd_auto = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (timers[i] > 0) begin
          timers[i]--;
          if (timers[i] == 0) rd_auto = 1'b1;
        end
      end
      if (prev_stall) begin
        chk("stall_kv_vld_held", 32'(kv_vld), 32'd1);
        chk("stall_payload_held", 32'(cur), 32'(prev_b));
      end
      if (q_req_vld && q_req_rdy) begin
        if (exp_q.size() == 0) begin
          chk("q_req_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          eq = exp_q.pop_front();
          chk("q_req_idx", 32'(q_idx), 32'(eq));
          $display("q_req  q_idx=%0d", q_idx);
        end
      end
      if (kv_vld && kv_rdy) begin
        if (exp_kv.size() == 0) begin
          chk("kv_unexpected", 32'(exp_kv.size()), 32'd1);
        end else begin
          e = exp_kv.pop_front();
          chk("kv_beat{q,k,first,last}", 32'(cur), 32'(e));
          $display("kv     q_idx=%0d kv_idx=%0d first=%0b last=%0b", q_idx, kv_idx, kv_first, kv_last);
        end
        if (kv_last && auto_en) begin
          for (int i = 0; i < 8; i++) begin
            if (timers[i] == 0) begin
              timers[i] = 3;
              break;
            end
          end
        end
      end
      if (done) begin
        chk("done_was_expected", 32'(exp_done > 0), 32'd1);
        chk("busy_low_at_done", 32'(busy), 32'd0);
        if (exp_done > 0) exp_done--;
        done_seen++;
        $display("done   stall_cnt=%0d", stall_cnt);
      end
      prev_stall = kv_vld && !kv_rdy;
      prev_b     = cur;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  base;
    logic found;
    rst = 1'b1; start = 1'b0; seq_len = '0; num_q = '0;
    q_req_rdy = 1'b1; kv_rdy = 1'b1; rd_man = 1'b0; auto_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    rst = 1'b0;

    // Two queries of four rows, row_done auto-generated.
    base = done_seen;
    push_job(4, 2);
    do_start(4, 2);
    wait_done(base, 200);
    end_checks();

    // seq_len=1: first and last on every beat; a start while busy must be ignored.
    base = done_seen;
    push_job(1, 3);
    do_start(1, 3);
    repeat (2) @(posedge clk);
    #1;
    seq_len = 7'd5; num_q = 7'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(base, 200);
    end_checks();

    // In-flight limit: third Q request held until a row_done arrives.
    auto_en = 1'b0;
    base = done_seen;
    push_job(2, 4);
    do_start(2, 4);
    repeat (30) @(posedge clk);
    #1;
    chk("third_req_held_low", 32'(q_req_vld), 32'd0);
    chk("third_req_q_idx", 32'(q_idx), 32'd2);
    rd_man = 1'b1;
    @(posedge clk); #1;
    chk("third_req_after_row_done", 32'(q_req_vld), 32'd1);
    auto_en = 1'b1;
    @(posedge clk); #1;
    rd_man = 1'b0;
    wait_done(base, 300);
    end_checks();

    // kv_rdy 1,0,0,1 around kv_idx 1..2.
    base = done_seen;
    push_job(4, 1);
    do_start(4, 1);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (kv_vld && kv_idx == 6'd1) begin
        found = 1'b1;
        break;
      end
    end
    chk("stall_setup_reached_idx1", 32'(found), 32'd1);
    @(posedge clk); #1;
    kv_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    kv_rdy = 1'b1;
    wait_done(base, 200);
`ifdef ROW_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, 32'd2);
`else
    chk("stall_cnt", stall_cnt, 32'd0);
`endif
    end_checks();

    // num_q=0: done the next cycle, nothing issued.
    base = done_seen;
    exp_done++;
    do_start(3, 0);
    chk("zero_done_pulse", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("zero_no_q_req", 32'(q_req_vld), 32'd0);
    chk("zero_done_count", 32'(done_seen - base), 32'd1);
    end_checks();

    // Reset mid-stream at kv_idx=2, then a fresh job.
    push_job(4, 2);
    do_start(4, 2);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (kv_vld && kv_idx == 6'd2) begin
        found = 1'b1;
        break;
      end
    end
    chk("reset_setup_reached_idx2", 32'(found), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset();
    chk("beats_left_at_reset", 32'(exp_kv.size()), 32'd6);
    chk("q_left_at_reset", 32'(exp_q.size()), 32'd1);
    exp_kv.delete();
    exp_q.delete();
    exp_done = 0;
    rst = 1'b0;
    base = done_seen;
    push_job(3, 1);
    do_start(3, 1);
    wait_done(base, 200);
    end_checks();

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
